synaptic_current: RTL and testbench

Upstream input stage for the EIF neuron: converts a bundle of binary presynaptic spikes into the 8-bit `current` operand the neuron integrates each cycle. Each input line has a programmable signed weight. Weighted spikes are summed into a synaptic-current accumulator. The accumulator decays exponentially on a programmable tick and saturates to the neuron's unsigned 8-bit input range.

---
 rtl/synaptic_pkg.sv | 30 +++
 rtl/spike_weight_sum.sv | 42 ++++
 rtl/synaptic_current.sv | 70 +++++++
 tb/tb_synaptic_current.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/synaptic_pkg.sv
// Shared widths, the write-port request and the arithmetic helpers
// used by the synaptic-current front end.
package synaptic_pkg;

   localparam int CUR_W = 8;
   localparam int W_W   = 8;
   localparam int SUM_W = 11;
   localparam int ACC_W = 12;

   typedef struct packed {
      logic                  en;
      logic [2:0]            addr;
      logic signed [W_W-1:0] data;
   } wr_req_t;

   function automatic logic [CUR_W-1:0] clamp_u8(input logic signed [ACC_W-1:0] t);
      if (t < 0)           return '0;
      else if (t > 12'sd255) return '1;
      else                 return t[CUR_W-1:0];
   endfunction

   // Always remove at least 1 so small currents still drain to zero.
   function automatic logic [CUR_W-1:0] decay_amt(input logic [CUR_W-1:0] i,
                                                  input int unsigned    sh);
      logic [CUR_W-1:0] d;
      d = i >> sh;
      return (d == '0) ? CUR_W'(1) : d;
   endfunction

endpackage

// File: rtl/spike_weight_sum.sv
// Weight register file plus the registered weighted sum of the
// spike lines sampled this cycle.
module spike_weight_sum
   import synaptic_pkg::*;
#(
   parameter int                    N_INPUTS    = 4,
   parameter logic signed [W_W-1:0] INIT_WEIGHT = 8'sd16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic [N_INPUTS-1:0]     spike_in,
   input  wr_req_t                 wr,
   output logic signed [SUM_W-1:0] sum
);

   logic [N_INPUTS-1:0][W_W-1:0] weight;
   logic signed [SUM_W-1:0]      sum_nxt;

   // Reads the pre-write weights, so a same-cycle write lands one spike later.
   always_comb begin
      sum_nxt = '0;
      for (int i = 0; i < N_INPUTS; i++)
         if (spike_in[i]) sum_nxt = sum_nxt + SUM_W'($signed(weight[i]));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_INPUTS; i++) weight[i] <= INIT_WEIGHT;
      end else begin
         for (int i = 0; i < N_INPUTS; i++)
            if (wr.en && wr.addr == 3'(i)) weight[i] <= wr.data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   sum <= '0;
      else if (ena) sum <= sum_nxt;
      else          sum <= '0;
   end

endmodule

// File: rtl/synaptic_current.sv
// Decaying, saturating synaptic-current accumulator feeding the EIF
// neuron; stage 1 (weighted spike sum) lives in spike_weight_sum.
module synaptic_current
   import synaptic_pkg::*;
#(
   parameter int                    N_INPUTS     = 4,
   parameter int                    DECAY_PERIOD = 4,
   parameter int                    DECAY_SHIFT  = 3,
   parameter logic signed [W_W-1:0] INIT_WEIGHT  = 8'sd16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [N_INPUTS-1:0] spike_in,
   input  logic                wr_en,
   input  logic [2:0]          wr_addr,
   input  logic [W_W-1:0]      wr_data,
   output logic [CUR_W-1:0]    current,
   output logic                sat
);

   localparam int CNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

   logic [CNT_W-1:0]        cnt;
   logic                    tick;
   logic signed [SUM_W-1:0] sum;
   logic [CUR_W-1:0]        id;
   logic signed [ACC_W-1:0] total;
   wr_req_t                 wr;

   assign wr = '{en: wr_en, addr: wr_addr, data: wr_data};

   spike_weight_sum #(
      .N_INPUTS    (N_INPUTS),
      .INIT_WEIGHT (INIT_WEIGHT)
   ) u_sum (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .spike_in (spike_in),
      .wr       (wr),
      .sum      (sum)
   );

   assign tick = ena && (cnt == CNT_W'(DECAY_PERIOD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt <= '0;
      else if (ena) cnt <= tick ? '0 : cnt + CNT_W'(1);
   end

   // Decay first, then add this cycle's stage-1 sum.
   always_comb begin
      id    = (tick && current != '0) ? current - decay_amt(current, DECAY_SHIFT) : current;
      total = $signed({{(ACC_W-CUR_W){1'b0}}, id}) + ACC_W'(sum);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         current <= '0;
         sat     <= 1'b0;
      end else if (ena) begin
         current <= clamp_u8(total);
         sat     <= (total > 12'sd255);
      end else begin
         sat     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_synaptic_current.sv
// Directed checks of synaptic_current with default parameters;
// decay ticks fall on enabled edges 4, 8, 12, ... after each reset.
module tb_synaptic_current;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [3:0] spike_in = '0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic [7:0] current;
   logic       sat;

   int nvec = 0;
   int nerr = 0;

   synaptic_current dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .spike_in (spike_in),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .current  (current),
      .sat      (sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      ena      = 1'b0;
      spike_in = '0;
      wr_en    = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Weight write with ena low so the counter and accumulator stay put.
   task automatic wr_w(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = 3'(a);
      wr_data = 8'(d);
      step();
      wr_en   = 1'b0;
   endtask

   initial begin
      // reset state and single spike latency
      step();
      chk("rst_cur", current, 0);
      chk("rst_sat", sat, 0);
      do_reset();
      ena = 1'b1;
      spike_in = 4'b0001;
      step();
      spike_in = '0;
      chk("lat_e1", current, 0);
      step();
      chk("lat_e2", current, 16);
      step();
      chk("lat_e3", current, 16);
      step();
      chk("lat_tick", current, 14);

      // saturation
      do_reset();
      for (int i = 0; i < 4; i++) wr_w(i, 127);
      ena = 1'b1;
      spike_in = 4'b1111;
      for (int e = 1; e <= 8; e++) begin
         step();
         if (e >= 2 && e <= 7) begin
            chk("sat_cur", current, 255);
            chk("sat_flag", sat, 1);
         end
         if (e == 6) spike_in = '0;
      end
      chk("sat_rel_cur", current, 224);
      chk("sat_rel_flag", sat, 0);

      // ena low freezes accumulator and counter, drops spikes
      ena = 1'b0;
      spike_in = 4'b1111;
      for (int e = 1; e <= 10; e++) begin
         step();
         chk("frz_cur", current, 224);
         chk("frz_sat", sat, 0);
      end
      ena = 1'b1;
      spike_in = '0;
      for (int e = 1; e <= 4; e++) begin
         step();
         chk("frz_resume", current, (e == 4) ? 196 : 224);
      end

      // decay from 200 down to 0 and hold
      do_reset();
      wr_w(0, 100);
      wr_w(1, 100);
      ena = 1'b1;
      spike_in = 4'b0011;
      for (int e = 1; e <= 152; e++) begin
         step();
         if (e == 1) spike_in = '0;
         case (e)
            3:   chk("dec_200", current, 200);
            4:   chk("dec_175", current, 175);
            7:   chk("dec_hold", current, 175);
            8:   chk("dec_154", current, 154);
            12:  chk("dec_135", current, 135);
            116: chk("dec_7", current, 7);
            120: chk("dec_6", current, 6);
            140: chk("dec_1", current, 1);
            144: chk("dec_0", current, 0);
            152: chk("dec_0hold", current, 0);
            default: ;
         endcase
      end

      // inhibition clamps at 0 without wrap or flag
      do_reset();
      wr_w(2, -50);
      wr_w(0, 30);
      ena = 1'b1;
      spike_in = 4'b0001;
      step();
      spike_in = 4'b0100;
      step();
      spike_in = '0;
      chk("inh_30", current, 30);
      step();
      chk("inh_cur", current, 0);
      chk("inh_sat", sat, 0);

      // write/spike collision and out-of-range write
      do_reset();
      ena = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'd100;
      spike_in = 4'b0010;
      step();
      wr_en = 1'b0;
      step();
      chk("col_old", current, 16);
      spike_in = '0;
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h80;
      step();
      chk("col_new", current, 116);
      wr_en = 1'b0;
      spike_in = 4'b1111;
      step();
      chk("col_tick", current, 102);
      spike_in = '0;
      step();
      chk("col_addr7", current, 250);
      chk("col_sat", sat, 0);

      // asynchronous reset mid-run, weights back to default
      #3 rst_n = 1'b0;
      #1;
      chk("arst_cur", current, 0);
      chk("arst_sat", sat, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      ena = 1'b1;
      spike_in = 4'b0010;
      step();
      spike_in = '0;
      step();
      chk("arst_w", current, 16);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
